// File: rtl/updown_counter_param.sv
// updown_counter_param: up/down counter over a runtime window [lo_lim, hi_lim]
// with programmable step, wrap or saturate at the window edge, and clamped
// parallel load.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   clr               synchronous clear to lo_lim (highest synchronous priority)
//   load, data        synchronous load of data, clamped into the window
//   en, mode, step    count enable, direction (1 = up), unsigned step size
//   sat               1 = saturate at the window edge, 0 = wrap to the opposite edge
//   lo_lim, hi_lim    unsigned window bounds
//   data_out          registered count
//   tc                registered one-cycle terminal-count pulse per boundary event
//   at_hi, at_lo      combinational: data_out equals hi_lim / lo_lim
//   cfg_err           combinational: lo_lim > hi_lim (load and count are frozen)
module updown_counter_param #(
    parameter int unsigned           WIDTH   = 32,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             at_hi,
    output logic             at_lo,
    output logic             cfg_err
);

    localparam int unsigned WX = WIDTH + 1;

    logic [WIDTH-1:0] data_q, data_d;
    logic             tc_q, tc_d;

    // Widened arithmetic so boundary compares never suffer a modular wrap.
    logic [WX-1:0] sum_w;
    logic [WX-1:0] lo_step_w;
    logic          up_evt_w;
    logic          dn_evt_w;
    logic          step_zero_w;

    assign sum_w       = {1'b0, data_q} + {1'b0, step};
    assign lo_step_w   = {1'b0, lo_lim} + {1'b0, step};
    assign up_evt_w    = sum_w > {1'b0, hi_lim};
    assign dn_evt_w    = {1'b0, data_q} < lo_step_w;
    assign step_zero_w = (step == '0);

    assign cfg_err = (lo_lim > hi_lim);
    assign at_hi   = (data_q == hi_lim);
    assign at_lo   = (data_q == lo_lim);

    assign data_out = data_q;
    assign tc       = tc_q;

    // Next-state: clr > (cfg_err freeze) > load > en > hold.
    always_comb begin
        data_d = data_q;
        tc_d   = 1'b0;
        if (clr) begin
            data_d = lo_lim;
        end else if (!cfg_err) begin
            if (load) begin
                if (data > hi_lim) begin
                    data_d = hi_lim;
                end else if (data < lo_lim) begin
                    data_d = lo_lim;
                end else begin
                    data_d = data;
                end
            end else if (en && !step_zero_w) begin
                if (mode) begin
                    if (up_evt_w) begin
                        data_d = sat ? hi_lim : lo_lim;
                        tc_d   = 1'b1;
                    end else begin
                        data_d = sum_w[WIDTH-1:0];
                    end
                end else begin
                    if (dn_evt_w) begin
                        data_d = sat ? lo_lim : hi_lim;
                        tc_d   = 1'b1;
                    end else begin
                        data_d = data_q - step;
                    end
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RST_VAL;
            tc_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            tc_q   <= tc_d;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param: the driver pushes hand-computed
// expectations, an independent monitor pops and compares after each edge (or
// on a mid-cycle check request used for asynchronous reset).
module tb_updown_counter_param;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr, load, en, mode, sat;
    logic [W-1:0] step, lo_lim, hi_lim, data;
    logic [W-1:0] data_out;
    logic         tc, at_hi, at_lo, cfg_err;

    typedef struct packed {
        logic [15:0]  id;
        logic [W-1:0] d;
        logic         tc;
        logic         hi;
        logic         lo;
        logic         ce;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec   = 0;
    event mid_chk;

    updown_counter_param #(.WIDTH(W), .RST_VAL('0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .en(en),
        .mode(mode), .sat(sat), .step(step), .lo_lim(lo_lim), .hi_lim(hi_lim),
        .data(data), .data_out(data_out), .tc(tc), .at_hi(at_hi),
        .at_lo(at_lo), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Build an expectation; flags follow from the expected count and limits.
    task automatic push_exp(input logic [W-1:0] ex_d, input logic ex_tc);
        exp_t x;
        x.id = 16'(vec);
        x.d  = ex_d;
        x.tc = ex_tc;
        x.hi = (ex_d == hi_lim);
        x.lo = (ex_d == lo_lim);
        x.ce = (lo_lim > hi_lim);
        sb_q.push_back(x);
        vec++;
    endtask

    task automatic apply(input logic c, input logic l, input logic e,
                         input logic m, input logic s,
                         input logic [W-1:0] st, input logic [W-1:0] lo_v,
                         input logic [W-1:0] hi_v, input logic [W-1:0] dt,
                         input logic [W-1:0] ex_d, input logic ex_tc);
        @(negedge clk);
        clr = c; load = l; en = e; mode = m; sat = s;
        step = st; lo_lim = lo_v; hi_lim = hi_v; data = dt;
        push_exp(ex_d, ex_tc);
    endtask

    // Drop rst_n between edges, check the forced state, release before the edge.
    task automatic pulse_reset(input logic [W-1:0] ex_after);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        push_exp('0, 1'b0);
        -> mid_chk;
        #2;
        rst_n = 1'b1;
        push_exp(ex_after, 1'b0);
    endtask

    // Monitor: compares whatever the DUT presents against the head of the queue.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk or mid_chk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                total++;
                if (data_out !== x.d || tc !== x.tc || at_hi !== x.hi ||
                    at_lo !== x.lo || cfg_err !== x.ce) begin
                    bad++;
                    $display("FAIL vec%0d: got d=%h tc=%b hi=%b lo=%b ce=%b, want d=%h tc=%b hi=%b lo=%b ce=%b",
                             x.id, data_out, tc, at_hi, at_lo, cfg_err,
                             x.d, x.tc, x.hi, x.lo, x.ce);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        clr = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b1; sat = 1'b0;
        step = 32'd1; lo_lim = '0; hi_lim = 32'hFFFF_FFFF; data = '0;
        // Reset state, checked between edges.
        #2;
        push_exp('0, 1'b0);
        -> mid_chk;
        @(negedge clk);
        rst_n = 1'b1;

        //     clr  ld  en  md  sat step     lo      hi            data           exp           tc
        // Legacy full-range wrap.
        apply(1'b0,1'b1,1'b0,1'b1,1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0);
        apply(1'b0,1'b0,1'b1,1'b1,1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b0);
        apply(1'b0,1'b0,1'b1,1'b1,1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0,         32'h0000_0000, 1'b1);
        apply(1'b0,1'b0,1'b0,1'b1,1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0,         32'h0000_0000, 1'b0);
        apply(1'b0,1'b0,1'b1,1'b0,1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b1);

        // Windowed down count: 16 -> 13 -> 10 -> wrap to 20 (10 < 10+3).
        apply(1'b0,1'b1,1'b0,1'b0,1'b0, 32'd3, 32'd10, 32'd20, 32'd16, 32'd16, 1'b0);
        apply(1'b0,1'b0,1'b1,1'b0,1'b0, 32'd3, 32'd10, 32'd20, 32'd0,  32'd13, 1'b0);
        apply(1'b0,1'b0,1'b1,1'b0,1'b0, 32'd3, 32'd10, 32'd20, 32'd0,  32'd10, 1'b0);
        apply(1'b0,1'b0,1'b1,1'b0,1'b0, 32'd3, 32'd10, 32'd20, 32'd0,  32'd20, 1'b1);

        // Saturate up: tc repeats while the event persists.
        apply(1'b0,1'b1,1'b0,1'b1,1'b1, 32'd7, 32'd0, 32'd100, 32'd98, 32'd98,  1'b0);
        apply(1'b0,1'b0,1'b1,1'b1,1'b1, 32'd7, 32'd0, 32'd100, 32'd0,  32'd100, 1'b1);
        apply(1'b0,1'b0,1'b1,1'b1,1'b1, 32'd7, 32'd0, 32'd100, 32'd0,  32'd100, 1'b1);
        apply(1'b0,1'b0,1'b0,1'b1,1'b1, 32'd7, 32'd0, 32'd100, 32'd0,  32'd100, 1'b0);

        // Load clamp and priority.
        apply(1'b0,1'b1,1'b0,1'b1,1'b0, 32'd1, 32'd5, 32'd50, 32'd60, 32'd50, 1'b0);
        apply(1'b0,1'b1,1'b0,1'b1,1'b0, 32'd1, 32'd5, 32'd50, 32'd2,  32'd5,  1'b0);
        apply(1'b0,1'b1,1'b1,1'b1,1'b0, 32'd1, 32'd5, 32'd50, 32'd20, 32'd20, 1'b0);
        apply(1'b1,1'b1,1'b0,1'b1,1'b0, 32'd1, 32'd5, 32'd50, 32'd40, 32'd5,  1'b0);
        // Step zero holds with no event.
        apply(1'b0,1'b0,1'b1,1'b0,1'b0, 32'd0, 32'd5, 32'd50, 32'd0,  32'd5,  1'b0);

        // Configuration error freezes load/count but not clear.
        apply(1'b0,1'b0,1'b1,1'b1,1'b0, 32'd1, 32'd30, 32'd20, 32'd0, 32'd5,  1'b0);
        apply(1'b0,1'b1,1'b0,1'b1,1'b0, 32'd1, 32'd30, 32'd20, 32'd7, 32'd5,  1'b0);
        apply(1'b1,1'b0,1'b0,1'b1,1'b0, 32'd1, 32'd30, 32'd20, 32'd0, 32'd30, 1'b0);
        apply(1'b0,1'b0,1'b1,1'b1,1'b0, 32'd1, 32'd30, 32'd40, 32'd0, 32'd31, 1'b0);

        // Degenerate window: both flags set, up event wraps onto the same value.
        apply(1'b1,1'b0,1'b0,1'b1,1'b0, 32'd1, 32'd7, 32'd7, 32'd0, 32'd7, 1'b0);
        apply(1'b0,1'b0,1'b1,1'b1,1'b0, 32'd1, 32'd7, 32'd7, 32'd0, 32'd7, 1'b1);

        // Async reset mid-count, then counting restarts from 0.
        apply(1'b0,1'b1,1'b0,1'b1,1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h1234, 32'h1234, 1'b0);
        apply(1'b0,1'b0,1'b1,1'b1,1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0,    32'h1235, 1'b0);
        pulse_reset(32'd1);
        apply(1'b0,1'b0,1'b1,1'b1,1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0,    32'd2,    1'b0);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
